mips_harvard_mem_sequencer: RTL and testbench
=============================================

# mips_harvard_mem_sequencer

Sequencer that lets the Harvard CPU core (`mips_cpu_harvard`) run from a single shared, single-port memory. It serialises each CPU instruction's fetch and optional data access onto the one memory port, buffers the results, and then releases the CPU for exactly one cycle through the CPU's `clk_enable`. It sits between the CPU and the unified memory model and replaces the separate instruction and data memories used in the per-instruction test benches.

## Interface
Parameters: none.

Ports:
- `clk` in 1 — single system clock.
- `reset` in 1 — asynchronous, active-high.
- `clk_enable` in 1 — global run enable; sampled only in FETCH_REQ.
- `cpu_active` in 1 — the CPU's `active` output.
- `cpu_clk_enable` out 1 — drives the CPU `clk_enable`; high for exactly one cycle per instruction.
- `cpu_instr_address` in 32 — the CPU's instruction address.
- `cpu_instr_readdata` out 32 — buffered instruction word, passed byte-for-byte unchanged from memory.
- `cpu_data_address` in 32, `cpu_data_read` in 1, `cpu_data_write` in 1, `cpu_data_writedata` in 32 — the CPU's data-side request.
- `cpu_data_readdata` out 32 — buffered load data.
- `mem_address` out 32, `mem_read` out 1, `mem_write` out 1, `mem_writedata` out 32 — shared memory request.
- `mem_readdata` in 32, `mem_waitrequest` in 1 — memory response.
  - A request is accepted in a cycle where it is asserted and `mem_waitrequest` is 0.
  - Read data is valid exactly 1 cycle after acceptance.
- `stall_cycles` out 32 — count of cycles with `cpu_clk_enable` = 0 while not HALTED.
- `protocol_error` out 1 — sticky flag.

## Operation
- FSM states: FETCH_REQ, FETCH_WAIT, DATA_REQ, DATA_WAIT, COMMIT, HALTED.
- FETCH_REQ
  - If `cpu_active` = 0, go to HALTED.
  - Else if `clk_enable` = 0, stay, with no memory request asserted.
  - Else drive `mem_read` = 1 and `mem_address` = `cpu_instr_address`. On acceptance, go to FETCH_WAIT.
- FETCH_WAIT: capture `mem_readdata` into the instruction buffer, which drives `cpu_instr_readdata` from the next cycle. Go to DATA_REQ.
- DATA_REQ
  - The CPU has now decoded the buffered instruction combinationally, so its data-side request is sampled here.
  - If `cpu_data_read` = 1: drive `mem_read` at `cpu_data_address`. On acceptance, go to DATA_WAIT.
  - Else if `cpu_data_write` = 1: drive `mem_write` with `cpu_data_writedata`. On acceptance, go to COMMIT.
  - Else (neither asserted): go to COMMIT without a memory request.
  - Read and write both asserted: perform the read only, suppress the write, set `protocol_error`.
- DATA_WAIT: capture `mem_readdata` into the data buffer (drives `cpu_data_readdata`). Go to COMMIT.
- COMMIT
  - `cpu_clk_enable` = 1 for this cycle only; the CPU retires the instruction on the following edge.
  - The CPU's `data_write` during COMMIT is not forwarded to memory; the write already happened in DATA_REQ.
  - Go to FETCH_REQ.
- HALTED: no memory traffic, `cpu_clk_enable` = 0, `stall_cycles` frozen. Left only via `reset`.
- Output hold rules:
  - `mem_*` outputs are 0 in every state and cycle where they are not being driven above.
  - The instruction and data buffers hold their values until overwritten.
  - `cpu_data_readdata` keeps the last load value across non-load instructions.
- `stall_cycles` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (asynchronous, immediate): state = FETCH_REQ.
  - 0: `cpu_clk_enable`, `mem_read`, `mem_write`, `protocol_error`, `mem_address`, `mem_writedata`, both buffers, `stall_cycles`.
  - Any in-flight memory read response is discarded.
  - Reset asserted mid-instruction aborts it with no COMMIT and no further memory writes.
- Cycles per instruction with `mem_waitrequest` = 0:
  - ALU/branch: 4 (FETCH_REQ, FETCH_WAIT, DATA_REQ, COMMIT).
  - Store: 4.
  - Load: 5.
  - Each cycle of `mem_waitrequest` = 1 in a request state adds 1 cycle.
- `clk_enable` going low mid-instruction does not affect the instruction; it takes effect at the next FETCH_REQ.
- `cpu_active` falling is seen at the next FETCH_REQ. The instruction in progress completes.

## Test plan
- Zero-wait ALU instruction:
  - Stimulus: after reset, memory returns 0x24846006 for address 0xBFC00000; CPU issues no data request.
  - Required: `mem_read` in cycle 1, FETCH_WAIT in cycle 2, `cpu_clk_enable` high only in cycle 4; `stall_cycles` = 3 after the first commit.
- Load with one wait state:
  - Stimulus: `cpu_data_read` = 1, address 0x00001000, memory holds 0xDEADBEEF, `mem_waitrequest` = 1 for the first data-request cycle.
  - Required: `cpu_data_readdata` = 0xDEADBEEF in COMMIT, which occurs in cycle 6.
- Store:
  - Stimulus: `cpu_data_write` = 1, address 0x00000010, data 0x12345678.
  - Required: exactly one `mem_write` pulse with those values, in DATA_REQ, before COMMIT; no `mem_write` in COMMIT.
- Conflicting request:
  - Stimulus: `cpu_data_read` and `cpu_data_write` both 1.
  - Required: read performed, no write pulse, `protocol_error` = 1 and still 1 after later clean instructions.
- Halt and global enable:
  - Stimulus: `cpu_active` = 0 at FETCH_REQ.
    - Required: HALTED, zero memory traffic for 20 cycles, `stall_cycles` unchanged.
  - Stimulus: `clk_enable` = 0 in FETCH_REQ.
    - Required: no `mem_read` until `clk_enable` returns to 1.
- Reset mid-load:
  - Stimulus: assert `reset` during DATA_WAIT.
  - Required: all outputs 0 immediately; next fetch at the CPU's reset address; stale read data never reaches `cpu_data_readdata`.

Source files
------------

// File: rtl/mips_harvard_mem_sequencer.sv
// Serialises each instruction's fetch and optional data access of a Harvard MIPS core
// onto one single-port memory, then releases the core for exactly one clock.
module mips_harvard_mem_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        cpu_active,
   output logic        cpu_clk_enable,
   input  logic [31:0] cpu_instr_address,
   output logic [31:0] cpu_instr_readdata,
   input  logic [31:0] cpu_data_address,
   input  logic        cpu_data_read,
   input  logic        cpu_data_write,
   input  logic [31:0] cpu_data_writedata,
   output logic [31:0] cpu_data_readdata,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   output logic [31:0] stall_cycles,
   output logic        protocol_error
);

   typedef enum logic [2:0] {
      FETCH_REQ,
      FETCH_WAIT,
      DATA_REQ,
      DATA_WAIT,
      COMMIT,
      HALTED
   } state_t;

   state_t state, state_next;
   logic   conflict;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH_REQ;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      mem_address    = 32'h0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_writedata  = 32'h0;
      cpu_clk_enable = 1'b0;
      conflict       = 1'b0;
      unique case (state)
         FETCH_REQ: begin
            if (!cpu_active) begin
               state_next = HALTED;
            end else if (clk_enable) begin
               mem_read    = 1'b1;
               mem_address = cpu_instr_address;
               if (!mem_waitrequest) state_next = FETCH_WAIT;
            end
         end
         FETCH_WAIT: state_next = DATA_REQ;
         DATA_REQ: begin
            // A simultaneous read and write is resolved as a read; the write is dropped.
            if (cpu_data_read) begin
               conflict    = cpu_data_write;
               mem_read    = 1'b1;
               mem_address = cpu_data_address;
               if (!mem_waitrequest) state_next = DATA_WAIT;
            end else if (cpu_data_write) begin
               mem_write     = 1'b1;
               mem_address   = cpu_data_address;
               mem_writedata = cpu_data_writedata;
               if (!mem_waitrequest) state_next = COMMIT;
            end else begin
               state_next = COMMIT;
            end
         end
         DATA_WAIT: state_next = COMMIT;
         COMMIT: begin
            cpu_clk_enable = 1'b1;
            state_next     = FETCH_REQ;
         end
         HALTED: state_next = HALTED;
         default: state_next = FETCH_REQ;
      endcase
      // Outputs go quiet the instant reset rises, not at the next edge.
      if (reset) begin
         mem_address    = 32'h0;
         mem_read       = 1'b0;
         mem_write      = 1'b0;
         mem_writedata  = 32'h0;
         cpu_clk_enable = 1'b0;
         conflict       = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_instr_readdata <= 32'h0;
         cpu_data_readdata  <= 32'h0;
         stall_cycles       <= 32'h0;
         protocol_error     <= 1'b0;
      end else begin
         if (state == FETCH_WAIT) cpu_instr_readdata <= mem_readdata;
         if (state == DATA_WAIT) cpu_data_readdata <= mem_readdata;
         if ((state != HALTED) && (state != COMMIT)) stall_cycles <= stall_cycles + 32'd1;
         if (conflict) protocol_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_harvard_mem_sequencer.sv
// Bench for mips_harvard_mem_sequencer: unified memory model, scripted CPU data side,
// scoreboard queues for fetched words, load data and store traffic.
module tb_mips_harvard_mem_sequencer;

   logic        clk = 1'b0;
   logic        reset, clk_enable, cpu_active, cpu_clk_enable;
   logic [31:0] cpu_instr_address, cpu_instr_readdata;
   logic [31:0] cpu_data_address, cpu_data_writedata, cpu_data_readdata;
   logic        cpu_data_read, cpu_data_write;
   logic [31:0] mem_address, mem_writedata;
   logic        mem_read, mem_write;
   logic [31:0] mem_readdata = 32'h0;
   logic        mem_waitrequest;
   logic [31:0] stall_cycles;
   logic        protocol_error;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] exp_instr_q[$], exp_data_q[$], exp_wr_addr_q[$], exp_wr_data_q[$];
   logic [31:0] exp_stall, pc, last_load, e;

   int          obs_commit, obs_wr_count, obs_wr_cyc;
   logic [31:0] obs_rd_cycles, obs_first_rd_addr, obs_wr_addr, obs_wr_data;
   logic [31:0] obs_instr, obs_data;
   logic        obs_wr_in_commit;

   mips_harvard_mem_sequencer dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .cpu_active(cpu_active),
      .cpu_clk_enable(cpu_clk_enable),
      .cpu_instr_address(cpu_instr_address), .cpu_instr_readdata(cpu_instr_readdata),
      .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
      .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
      .cpu_data_readdata(cpu_data_readdata),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_waitrequest(mem_waitrequest),
      .stall_cycles(stall_cycles), .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   // Memory model: read data valid only in the cycle after acceptance, garbage otherwise.
   always @(posedge clk) begin
      if (mem_read && !mem_waitrequest)
         mem_readdata <= mem.exists(mem_address) ? mem[mem_address] : 32'h0;
      else
         mem_readdata <= 32'hBAD0BAD0;
      if (mem_write && !mem_waitrequest) mem[mem_address] = mem_writedata;
   end

   task automatic setup(input logic [31:0] instr, input logic rd, input logic wr,
                        input logic [31:0] daddr, input logic [31:0] wdata);
      cpu_instr_address  = pc;
      mem[pc]            = instr;
      exp_instr_q.push_back(instr);
      cpu_data_read      = rd;
      cpu_data_write     = wr;
      cpu_data_address   = daddr;
      cpu_data_writedata = wdata;
      pc = pc + 32'd4;
   endtask

   // Runs one instruction from FETCH_REQ (entered at posedge+1) to the cycle after COMMIT.
   task automatic run_instr(input logic [31:0] wmask, input int drop_cyc);
      obs_commit = 0; obs_wr_count = 0; obs_wr_cyc = 0; obs_rd_cycles = 32'h0;
      obs_first_rd_addr = 32'h0; obs_wr_addr = 32'h0; obs_wr_data = 32'h0;
      obs_instr = 32'h0; obs_data = 32'h0; obs_wr_in_commit = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         mem_waitrequest = (cyc <= 32) ? wmask[cyc-1] : 1'b0;
         if (cyc == drop_cyc) clk_enable = 1'b0;
         #1;
         if (mem_read && cyc <= 32) begin
            if (obs_rd_cycles == 32'h0) obs_first_rd_addr = mem_address;
            obs_rd_cycles[cyc-1] = 1'b1;
         end
         if (mem_write && !mem_waitrequest) begin
            obs_wr_count++; obs_wr_addr = mem_address; obs_wr_data = mem_writedata; obs_wr_cyc = cyc;
         end
         if (mem_write && cpu_clk_enable) obs_wr_in_commit = 1'b1;
         if (cpu_clk_enable) begin
            obs_commit = cyc; obs_instr = cpu_instr_readdata; obs_data = cpu_data_readdata;
         end
         @(posedge clk); #1;
         if (obs_commit != 0) break;
      end
      mem_waitrequest = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; clk_enable = 1'b1; cpu_active = 1'b1; mem_waitrequest = 1'b0;
      cpu_data_read = 1'b0; cpu_data_write = 1'b0; cpu_data_address = 32'h0;
      cpu_data_writedata = 32'h0; pc = 32'hBFC00000; cpu_instr_address = pc;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({cpu_clk_enable, mem_read, mem_write, protocol_error} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 0000", {cpu_clk_enable, mem_read, mem_write, protocol_error}); end
      checks++; if ({mem_address, mem_writedata} !== 64'h0) begin
         errors++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_address, mem_writedata}); end
      checks++; if ({cpu_instr_readdata, cpu_data_readdata, stall_cycles} !== 96'h0) begin
         errors++; $display("FAIL reset_regs: got %h expected 0", {cpu_instr_readdata, cpu_data_readdata, stall_cycles}); end
      reset = 1'b0;
      exp_stall = 32'h0; last_load = 32'h0;
   endtask

   task automatic test_alu();
      setup(32'h24846006, 1'b0, 1'b0, 32'h0, 32'h0);
      run_instr(32'h0, 0);
      exp_stall += 3;
      checks++; if (obs_commit !== 4) begin errors++; $display("FAIL alu_commit_cycle: got %0d expected 4", obs_commit); end
      checks++; if (obs_rd_cycles !== 32'h1) begin errors++; $display("FAIL alu_read_cycles: got %h expected 1", obs_rd_cycles); end
      checks++; if (obs_first_rd_addr !== 32'hBFC00000) begin errors++; $display("FAIL alu_fetch_addr: got %h expected bfc00000", obs_first_rd_addr); end
      e = exp_instr_q.pop_front();
      checks++; if (obs_instr !== e) begin errors++; $display("FAIL alu_instr: got %h expected %h", obs_instr, e); end
      checks++; if (obs_wr_count !== 0) begin errors++; $display("FAIL alu_writes: got %0d expected 0", obs_wr_count); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL alu_stall: got %0d expected %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_load_wait();
      setup(32'h8C021000, 1'b1, 1'b0, 32'h00001000, 32'h0);
      mem[32'h00001000] = 32'hDEADBEEF;
      exp_data_q.push_back(32'hDEADBEEF);
      run_instr(32'b100, 0);
      exp_stall += 5;
      checks++; if (obs_commit !== 6) begin errors++; $display("FAIL load_commit_cycle: got %0d expected 6", obs_commit); end
      checks++; if (obs_rd_cycles !== 32'b1101) begin errors++; $display("FAIL load_read_cycles: got %b expected 1101", obs_rd_cycles); end
      e = exp_data_q.pop_front();
      checks++; if (obs_data !== e) begin errors++; $display("FAIL load_data: got %h expected %h", obs_data, e); end
      last_load = e;
      e = exp_instr_q.pop_front();
      checks++; if (obs_instr !== e) begin errors++; $display("FAIL load_instr: got %h expected %h", obs_instr, e); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL load_stall: got %0d expected %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_store();
      setup(32'hAC030010, 1'b0, 1'b1, 32'h00000010, 32'h12345678);
      exp_wr_addr_q.push_back(32'h00000010); exp_wr_data_q.push_back(32'h12345678);
      run_instr(32'h0, 0);
      exp_stall += 3;
      checks++; if (obs_commit !== 4) begin errors++; $display("FAIL store_commit_cycle: got %0d expected 4", obs_commit); end
      checks++; if (obs_wr_count !== 1) begin errors++; $display("FAIL store_pulses: got %0d expected 1", obs_wr_count); end
      checks++; if (obs_wr_cyc !== 3) begin errors++; $display("FAIL store_cycle: got %0d expected 3", obs_wr_cyc); end
      e = exp_wr_addr_q.pop_front();
      checks++; if (obs_wr_addr !== e) begin errors++; $display("FAIL store_addr: got %h expected %h", obs_wr_addr, e); end
      e = exp_wr_data_q.pop_front();
      checks++; if (obs_wr_data !== e) begin errors++; $display("FAIL store_data: got %h expected %h", obs_wr_data, e); end
      checks++; if (obs_wr_in_commit !== 1'b0) begin errors++; $display("FAIL store_in_commit: got %b expected 0", obs_wr_in_commit); end
      checks++; if (obs_data !== last_load) begin errors++; $display("FAIL store_keeps_load: got %h expected %h", obs_data, last_load); end
      e = exp_instr_q.pop_front();
      checks++; if (obs_instr !== e) begin errors++; $display("FAIL store_instr: got %h expected %h", obs_instr, e); end
   endtask

   task automatic test_conflict();
      setup(32'hFC002000, 1'b1, 1'b1, 32'h00002000, 32'hFFFFFFFF);
      mem[32'h00002000] = 32'hCAFEF00D;
      exp_data_q.push_back(32'hCAFEF00D);
      run_instr(32'h0, 0);
      exp_stall += 4;
      checks++; if (obs_commit !== 5) begin errors++; $display("FAIL conflict_commit_cycle: got %0d expected 5", obs_commit); end
      checks++; if (obs_wr_count !== 0) begin errors++; $display("FAIL conflict_writes: got %0d expected 0", obs_wr_count); end
      e = exp_data_q.pop_front();
      checks++; if (obs_data !== e) begin errors++; $display("FAIL conflict_read: got %h expected %h", obs_data, e); end
      last_load = e;
      checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL conflict_flag: got %b expected 1", protocol_error); end
      void'(exp_instr_q.pop_front());
      setup(32'h00851020, 1'b0, 1'b0, 32'h0, 32'h0);
      run_instr(32'h0, 0);
      exp_stall += 3;
      void'(exp_instr_q.pop_front());
      checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b expected 1", protocol_error); end
      checks++; if (obs_data !== last_load) begin errors++; $display("FAIL conflict_keeps_load: got %h expected %h", obs_data, last_load); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL conflict_stall: got %0d expected %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_enable();
      int reads;
      setup(32'h24A50001, 1'b0, 1'b0, 32'h0, 32'h0);
      run_instr(32'h0, 2);
      exp_stall += 3;
      checks++; if (obs_commit !== 4) begin errors++; $display("FAIL enable_drop_commit: got %0d expected 4", obs_commit); end
      e = exp_instr_q.pop_front();
      checks++; if (obs_instr !== e) begin errors++; $display("FAIL enable_drop_instr: got %h expected %h", obs_instr, e); end
      reads = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (mem_read || mem_write || cpu_clk_enable) reads++;
         @(posedge clk); #1;
      end
      exp_stall += 5;
      checks++; if (reads !== 0) begin errors++; $display("FAIL enable_idle_traffic: got %0d expected 0", reads); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL enable_idle_stall: got %0d expected %0d", stall_cycles, exp_stall); end
      clk_enable = 1'b1;
      setup(32'h24A50002, 1'b0, 1'b0, 32'h0, 32'h0);
      run_instr(32'h0, 0);
      exp_stall += 3;
      checks++; if (obs_rd_cycles !== 32'h1) begin errors++; $display("FAIL enable_resume_reads: got %h expected 1", obs_rd_cycles); end
      e = exp_instr_q.pop_front();
      checks++; if (obs_instr !== e) begin errors++; $display("FAIL enable_resume_instr: got %h expected %h", obs_instr, e); end
   endtask

   task automatic test_back_to_back();
      int kind, w, exp_commit;
      logic [31:0] mask, daddr, val;
      for (int i = 0; i < 6; i++) begin
         kind = i % 3;
         w = $urandom_range(0, 2);
         mask = (32'd1 << w) - 32'd1;
         exp_commit = 4 + w + ((kind == 1) ? 1 : 0);
         val = $urandom;
         if (kind == 1) begin
            daddr = 32'h4000 + 32'(i * 4);
            mem[daddr] = val;
            exp_data_q.push_back(val);
            setup(32'h8C000000 | daddr, 1'b1, 1'b0, daddr, 32'h0);
         end else if (kind == 2) begin
            daddr = 32'h5000 + 32'(i * 4);
            exp_wr_addr_q.push_back(daddr); exp_wr_data_q.push_back(val);
            setup(32'hAC000000 | daddr, 1'b0, 1'b1, daddr, val);
         end else begin
            setup(32'h20000000 | 32'(i), 1'b0, 1'b0, 32'h0, 32'h0);
         end
         run_instr(mask, 0);
         exp_stall += 32'(exp_commit - 1);
         checks++; if (obs_commit !== exp_commit) begin errors++; $display("FAIL b2b_commit[%0d]: got %0d expected %0d", i, obs_commit, exp_commit); end
         e = exp_instr_q.pop_front();
         checks++; if (obs_instr !== e) begin errors++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, obs_instr, e); end
         if (kind == 1) begin
            last_load = exp_data_q.pop_front();
         end else if (kind == 2) begin
            e = exp_wr_addr_q.pop_front();
            checks++; if (obs_wr_count !== 1 || obs_wr_addr !== e) begin errors++; $display("FAIL b2b_store_addr[%0d]: got %0d x %h expected 1 x %h", i, obs_wr_count, obs_wr_addr, e); end
            e = exp_wr_data_q.pop_front();
            checks++; if (obs_wr_data !== e) begin errors++; $display("FAIL b2b_store_data[%0d]: got %h expected %h", i, obs_wr_data, e); end
         end
         checks++; if (obs_data !== last_load) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, obs_data, last_load); end
      end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL b2b_stall: got %0d expected %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_halt();
      int traffic;
      cpu_active = 1'b0;
      #1;
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL halt_no_fetch: got %b expected 0", mem_read); end
      @(posedge clk); #1;
      exp_stall += 1;
      cpu_active = 1'b1;
      traffic = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (mem_read || mem_write || cpu_clk_enable) traffic++;
         @(posedge clk); #1;
      end
      checks++; if (traffic !== 0) begin errors++; $display("FAIL halt_traffic: got %0d expected 0", traffic); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL halt_stall_frozen: got %0d expected %0d", stall_cycles, exp_stall); end
   endtask

   task automatic test_reset_mid_load();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_instr_q.delete(); exp_data_q.delete();
      pc = 32'hBFC00100;
      mem[32'h00003000] = 32'h55AA55AA;
      setup(32'h8C013000, 1'b1, 1'b0, 32'h00003000, 32'h0);
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (cpu_instr_readdata !== 32'h8C013000) begin errors++; $display("FAIL rml_fetched: got %h expected 8c013000", cpu_instr_readdata); end
      reset = 1'b1;
      #1;
      checks++; if ({cpu_clk_enable, mem_read, mem_write, protocol_error} !== 4'b0) begin
         errors++; $display("FAIL rml_ctrl: got %b expected 0000", {cpu_clk_enable, mem_read, mem_write, protocol_error}); end
      checks++; if ({cpu_instr_readdata, cpu_data_readdata, stall_cycles} !== 96'h0) begin
         errors++; $display("FAIL rml_regs: got %h expected 0", {cpu_instr_readdata, cpu_data_readdata, stall_cycles}); end
      @(posedge clk); #1;
      reset = 1'b0;
      exp_instr_q.delete();
      exp_stall = 32'h0;
      pc = 32'hBFC00000;
      setup(32'h24846006, 1'b0, 1'b0, 32'h0, 32'h0);
      run_instr(32'h0, 0);
      exp_stall += 3;
      checks++; if (obs_first_rd_addr !== 32'hBFC00000) begin errors++; $display("FAIL rml_refetch_addr: got %h expected bfc00000", obs_first_rd_addr); end
      e = exp_instr_q.pop_front();
      checks++; if (obs_instr !== e) begin errors++; $display("FAIL rml_instr: got %h expected %h", obs_instr, e); end
      checks++; if (obs_data !== 32'h0) begin errors++; $display("FAIL rml_stale_data: got %h expected 0", obs_data); end
      checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL rml_stall: got %0d expected %0d", stall_cycles, exp_stall); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_wait();
      test_store();
      test_conflict();
      test_enable();
      test_back_to_back();
      test_halt();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
